// File: rtl/alu_step_controller_if.sv
// Operator-panel bundle for the single-step ALU controller: raw step/run/switch inputs
// and the architectural state shown on the panel.
interface alu_step_controller_if;
    logic       step;
    logic       run;
    logic [7:0] switches;
    logic [7:0] instruction;
    logic [3:0] accumulator;
    logic [3:0] index;
    logic [3:0] status;
    logic       busy;
    logic [1:0] state;

    modport master (
        output step, run, switches,
        input  instruction, accumulator, index, status, busy, state
    );

    modport slave (
        input  step, run, switches,
        output instruction, accumulator, index, status, busy, state
    );
endinterface

// File: rtl/alu_step_controller.sv
// Single-step / free-running 4-bit ALU controller with a debounced STEP button.
// Each instruction walks IDLE -> FETCH -> EXEC -> WRITE; only WRITE touches A, X and status.
module alu_step_controller #(
    parameter int unsigned DEBOUNCE = 3
) (
    input logic                  clk,
    input logic                  rst_n,
    alu_step_controller_if.slave bus
);
    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StFetch = 2'b01,
        StExec  = 2'b10,
        StWrite = 2'b11
    } state_e;

    localparam logic [3:0] DebMax  = 4'(DEBOUNCE);
    localparam logic [3:0] DebLast = 4'(DEBOUNCE - 1);

    logic [1:0] sync_q;
    logic [3:0] cnt_q;
    logic       deb_q;
    logic       deb_prev_q;
    logic       step_pulse;

    state_e     state_q;
    logic [7:0] ir_q;
    logic [3:0] a_q;
    logic [3:0] x_q;
    logic [3:0] st_q;
    logic [3:0] res_q;
    logic [3:0] flg_q;
    logic       wr_a_q;
    logic       wr_x_q;
    logic       wr_st_q;

    logic [3:0] op;
    logic [3:0] imm;
    logic [3:0] res;
    logic [4:0] t;
    logic       c;
    logic       v;
    logic       wr_a;
    logic       wr_x;
    logic       wr_st;

    // Debounced level rises once sync_q[1] has been high DEBOUNCE consecutive cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q     <= 2'b00;
            cnt_q      <= 4'd0;
            deb_q      <= 1'b0;
            deb_prev_q <= 1'b0;
        end else begin
            sync_q     <= {sync_q[0], bus.step};
            deb_prev_q <= deb_q;
            deb_q      <= sync_q[1] && (cnt_q >= DebLast);
            if (!sync_q[1]) begin
                cnt_q <= 4'd0;
            end else if (cnt_q != DebMax) begin
                cnt_q <= cnt_q + 4'd1;
            end
        end
    end

    assign step_pulse = deb_q & ~deb_prev_q;

    assign op  = ir_q[7:4];
    assign imm = ir_q[3:0];

    always_comb begin
        t     = 5'd0;
        res   = a_q;
        c     = 1'b0;
        v     = 1'b0;
        wr_a  = 1'b0;
        wr_x  = 1'b0;
        wr_st = 1'b1;
        case (op)
            4'h1: begin res = imm; wr_a = 1'b1; end
            4'h2: begin res = imm; wr_x = 1'b1; end
            4'h3: begin
                t = {1'b0, a_q} + {1'b0, imm};
                res = t[3:0]; c = t[4]; wr_a = 1'b1;
                v = (a_q[3] == imm[3]) && (res[3] != a_q[3]);
            end
            4'h4: begin
                t = {1'b0, a_q} - {1'b0, imm};
                res = t[3:0]; c = t[4]; wr_a = 1'b1;
                v = (a_q[3] != imm[3]) && (res[3] != a_q[3]);
            end
            4'h5: begin res = a_q & imm; wr_a = 1'b1; end
            4'h6: begin res = a_q | imm; wr_a = 1'b1; end
            4'h7: begin res = a_q ^ imm; wr_a = 1'b1; end
            4'h8: begin
                t = {1'b0, a_q} + {1'b0, x_q};
                res = t[3:0]; c = t[4]; wr_a = 1'b1;
                v = (a_q[3] == x_q[3]) && (res[3] != a_q[3]);
            end
            4'h9: begin res = a_q; wr_x = 1'b1; end
            4'hA: begin
                t = {1'b0, x_q} + 5'd1;
                res = t[3:0]; c = t[4]; wr_x = 1'b1;
                v = ~x_q[3] & res[3];
            end
            4'hB: begin
                t = {1'b0, x_q} - 5'd1;
                res = t[3:0]; c = t[4]; wr_x = 1'b1;
                v = x_q[3] & ~res[3];
            end
            4'hC: begin res = {a_q[2:0], 1'b0}; c = a_q[3]; wr_a = 1'b1; end
            4'hD: begin res = {1'b0, a_q[3:1]}; c = a_q[0]; wr_a = 1'b1; end
            default: wr_st = 1'b0;
        endcase
    end

    // EXEC only captures temporaries, so a reset before WRITE leaves no partial update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            ir_q    <= 8'h00;
            a_q     <= 4'h0;
            x_q     <= 4'h0;
            st_q    <= 4'h0;
            res_q   <= 4'h0;
            flg_q   <= 4'h0;
            wr_a_q  <= 1'b0;
            wr_x_q  <= 1'b0;
            wr_st_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (step_pulse || bus.run) state_q <= StFetch;
                end
                StFetch: begin
                    ir_q    <= bus.switches;
                    state_q <= StExec;
                end
                StExec: begin
                    res_q   <= res;
                    flg_q   <= {c, (res == 4'h0), res[3], v};
                    wr_a_q  <= wr_a;
                    wr_x_q  <= wr_x;
                    wr_st_q <= wr_st;
                    state_q <= StWrite;
                end
                StWrite: begin
                    if (wr_a_q)  a_q  <= res_q;
                    if (wr_x_q)  x_q  <= res_q;
                    if (wr_st_q) st_q <= flg_q;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.instruction = ir_q;
    assign bus.accumulator = a_q;
    assign bus.index       = x_q;
    assign bus.status      = st_q;
    assign bus.state       = state_q;
    assign bus.busy        = (state_q != StIdle);
endmodule

// File: tb/tb_alu_step_controller.sv
// Scoreboard bench for alu_step_controller: a plain-arithmetic model queues the expected
// architectural state per instruction; a monitor checks each WRITE->IDLE completion.
module tb_alu_step_controller;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_step_controller_if bus ();

    alu_step_controller #(.DEBOUNCE(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [7:0] ir;
        logic [3:0] a;
        logic [3:0] x;
        logic [3:0] s;
    } exp_t;

    exp_t       exp_q[$];
    logic [3:0] m_a, m_x, m_s;
    int         total = 0;
    int         bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    function automatic int sgn(input int n);
        return (n >= 8) ? n - 16 : n;
    endfunction

    // Reference: result and flags from plain integer arithmetic on the 4-bit values.
    function automatic void push_model(input logic [7:0] ir);
        int   op, imm, a, x, r, sr;
        bit   c, v, to_a, to_x, fl;
        exp_t e;
        op = int'(ir[7:4]); imm = int'(ir[3:0]); a = int'(m_a); x = int'(m_x);
        r = 0; sr = 0; c = 0; v = 0; to_a = 0; to_x = 0; fl = 1;
        case (op)
            1:  begin r = imm; to_a = 1; end
            2:  begin r = imm; to_x = 1; end
            3:  begin r = a + imm; c = (r > 15); sr = sgn(a) + sgn(imm);
                      v = (sr > 7 || sr < -8); to_a = 1; end
            4:  begin r = a - imm; c = (a < imm); sr = sgn(a) - sgn(imm);
                      v = (sr > 7 || sr < -8); to_a = 1; end
            5:  begin r = a & imm; to_a = 1; end
            6:  begin r = a | imm; to_a = 1; end
            7:  begin r = a ^ imm; to_a = 1; end
            8:  begin r = a + x; c = (r > 15); sr = sgn(a) + sgn(x);
                      v = (sr > 7 || sr < -8); to_a = 1; end
            9:  begin r = a; to_x = 1; end
            10: begin r = x + 1; c = (r > 15); v = (sgn(x) + 1 > 7); to_x = 1; end
            11: begin r = x - 1; c = (x < 1); v = (sgn(x) - 1 < -8); to_x = 1; end
            12: begin r = a * 2; c = (r > 15); to_a = 1; end
            13: begin r = a / 2; c = (a % 2 == 1); to_a = 1; end
            default: fl = 0;
        endcase
        r = ((r % 16) + 16) % 16;
        if (to_a) m_a = 4'(r);
        if (to_x) m_x = 4'(r);
        if (fl) m_s = {c, (r == 0), (r >= 8), v};
        e.ir = ir; e.a = m_a; e.x = m_x; e.s = m_s;
        exp_q.push_back(e);
    endfunction

    // Monitor: every WRITE->IDLE transition is one completed instruction.
    initial begin
        logic [1:0] prev;
        exp_t       e;
        prev = 2'b00;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev = 2'b00;
            end else begin
                if (prev == 2'b11 && bus.state == 2'b00) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_exec: got ir=%0h want no instruction",
                                 bus.instruction);
                    end else begin
                        e = exp_q.pop_front();
                        check("sb_ir", 32'(bus.instruction), 32'(e.ir));
                        check("sb_a", 32'(bus.accumulator), 32'(e.a));
                        check("sb_x", 32'(bus.index), 32'(e.x));
                        check("sb_status", 32'(bus.status), 32'(e.s));
                    end
                end
                prev = bus.state;
            end
        end
    end

    task automatic press(input logic [7:0] sw, input int hold, input bit do_exec,
                         input bit chg);
        bit seen, changed;
        seen = 0; changed = 0;
        bus.switches = sw;
        if (do_exec) push_model(sw);
        for (int i = 0; i < hold + 14; i++) begin
            @(posedge clk); #1;
            bus.step = (i < hold);
            // Busy was seen one edge ago, so FETCH has already latched IR.
            if (chg && seen && !changed) begin
                bus.switches = 8'($urandom);
                changed = 1;
            end
            if (bus.busy) seen = 1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.step = 1'b0; bus.run = 1'b0; bus.switches = 8'h00;
        exp_q.delete();
        m_a = 4'h0; m_x = 4'h0; m_s = 4'h0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        do_reset();
        check("rst_state", 32'(bus.state), 32'h0);
        check("rst_busy", 32'(bus.busy), 32'h0);
        check("rst_ir", 32'(bus.instruction), 32'h0);
        check("rst_a", 32'(bus.accumulator), 32'h0);
        check("rst_x", 32'(bus.index), 32'h0);
        check("rst_status", 32'(bus.status), 32'h0);
        rst_n = 1'b1;

        press(8'h15, 20, 1, 0);
        check("hold20_ir", 32'(bus.instruction), 32'h15);
        check("hold20_a", 32'(bus.accumulator), 32'h5);
        check("hold20_status", 32'(bus.status), 32'h0);

        press(8'h1F, 5, 1, 0);
        press(8'h31, 5, 1, 0);
        check("add_wrap_a", 32'(bus.accumulator), 32'h0);
        check("add_wrap_status", 32'(bus.status), 32'hC);
        press(8'h17, 5, 1, 0);
        press(8'h31, 5, 1, 0);
        check("add_ovf_a", 32'(bus.accumulator), 32'h8);
        check("add_ovf_status", 32'(bus.status), 32'h3);

        press(8'h13, 5, 1, 0);
        press(8'h45, 5, 1, 0);
        check("sub_a", 32'(bus.accumulator), 32'hE);
        check("sub_status", 32'(bus.status), 32'hA);
        press(8'h20, 5, 1, 0);
        press(8'hB0, 5, 1, 0);
        check("dex_x", 32'(bus.index), 32'hF);
        check("dex_cnv", 32'({bus.status[3], bus.status[1], bus.status[0]}), 32'h6);

        // Two-cycle glitch must not reach the debounced level.
        press(8'h1F, 2, 0, 0);
        check("glitch_a", 32'(bus.accumulator), 32'hE);

        // Instruction launched by a one-cycle RUN; the step pulse lands while busy.
        bus.switches = 8'h1A;
        push_model(8'h1A);
        @(posedge clk); #1;
        bus.step = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            if (k == 3) bus.run = 1'b1;
            if (k == 4) bus.run = 1'b0;
        end
        bus.step = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("busy_step_a", 32'(bus.accumulator), 32'hA);

        // Free-running: four INX, busy low one cycle in four.
        press(8'h20, 5, 1, 0);
        bus.switches = 8'hA0;
        for (int n = 0; n < 4; n++) push_model(8'hA0);
        @(posedge clk); #1;
        bus.run = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk); #1;
            if (k == 14) bus.run = 1'b0;
            @(negedge clk);
            check($sformatf("run_busy_%0d", k), 32'(bus.busy), 32'(k % 4 != 0));
        end
        repeat (6) @(posedge clk);
        #1;
        check("run_x", 32'(bus.index), 32'h4);
        check("run_stopped", 32'(bus.busy), 32'h0);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 4) == 0)
                press(8'($urandom), int'($urandom_range(1, 2)), 0, 0);
            else
                press(8'($urandom), int'($urandom_range(3, 10)), 1,
                      1'($urandom_range(0, 1)));
        end

        // Reset in the middle of EXEC: nothing of the ADD may survive.
        press(8'h15, 5, 1, 0);
        bus.switches = 8'h31;
        bus.step = 1'b1;
        for (int i = 0; i < 20 && !bus.busy; i++) @(negedge clk);
        check("reach_busy", 32'(bus.busy), 32'h1);
        @(posedge clk); #1;
        check("in_exec", 32'(bus.state), 32'h2);
        rst_n = 1'b0;
        #1;
        check("mid_rst_state", 32'(bus.state), 32'h0);
        check("mid_rst_busy", 32'(bus.busy), 32'h0);
        check("mid_rst_ir", 32'(bus.instruction), 32'h0);
        check("mid_rst_a", 32'(bus.accumulator), 32'h0);
        check("mid_rst_x", 32'(bus.index), 32'h0);
        check("mid_rst_status", 32'(bus.status), 32'h0);
        do_reset();
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("post_rst_idle", 32'(bus.state), 32'h0);
        press(8'h17, 4, 1, 0);
        check("post_rst_a", 32'(bus.accumulator), 32'h7);

        check("queue_empty", 32'(exp_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_step_controller.md
ALU_STEP_CONTROLLER -- requirements
Module: alu_step_controller

Interface
REQ-001 Parameter DEBOUNCE, default 3: consecutive cycles the synchronized STEP must be high before it is accepted (range 1..15).
REQ-002 CLK  in  1  sole clock; all state changes on its rising edge.
REQ-003 RST_N  in  1  reset; asynchronous assertion, active-low.
REQ-004 STEP  in  1  raw push-button, active-high, asynchronous to CLK.
REQ-005 RUN  in  1  level; 1 = execute continuously, 0 = single-step.
REQ-006 switches  in  8  instruction source: [7:4] opcode, [3:0] immediate.
REQ-007 instruction  out  8  latched instruction register (IR).
REQ-008 accumulator  out  4  register A.
REQ-009 index  out  4  register X.
REQ-010 status  out  4  flags: [3] C, [2] Z, [1] N, [0] V.
REQ-011 busy  out  1  high whenever state is not IDLE.
REQ-012 state  out  2  IDLE=00, FETCH=01, EXEC=10, WRITE=11.

Function
REQ-013 STEP passes through a 2-flop synchronizer, then a saturating counter; the debounced level goes high once the synchronized input has been high for DEBOUNCE consecutive cycles, and goes low on the first synchronized low.
REQ-014 The step pulse is one cycle wide, on the debounced level's rising edge only; holding STEP high yields exactly one pulse.
REQ-015 IDLE -> FETCH on the next edge when (step pulse or RUN=1); otherwise IDLE holds.
REQ-016 FETCH: IR <= switches; -> EXEC unconditionally.
REQ-017 EXEC: result and flags computed from IR, A, X into internal temporaries; no architectural register changes; -> WRITE.
REQ-018 WRITE: destination register and status updated; -> IDLE.
REQ-019 Step pulses arriving outside IDLE are discarded, not queued.
REQ-020 With RUN=1 held, one instruction completes every 4 cycles; IDLE lasts exactly one cycle between instructions.
REQ-021 Opcodes: 0 NOP; 1 LDA A<=imm; 2 LDX X<=imm; 3 ADD A<=A+imm; 4 SUB A<=A-imm; 5 AND; 6 OR; 7 XOR (A op imm -> A); 8 ADX A<=A+X; 9 TAX X<=A; A INX X<=X+1; B DEX X<=X-1; C SHL A<=A<<1; D SHR A<=A>>1 (logical); E,F behave as NOP.
REQ-022 Results are 4-bit modulo 16; wrap-around is silent apart from flags.
REQ-023 Z = (result==0); N = result[3] for every opcode 1..D.
REQ-024 C: ADD/ADX/INX = carry out of bit 3; SUB/DEX = borrow (1 when minuend < subtrahend); SHL = old A[3]; SHR = old A[0]; all other opcodes 1..D clear C.
REQ-025 V: signed overflow for ADD/ADX/SUB/INX/DEX; 0 for all other opcodes 1..D.
REQ-026 NOP and E/F leave A, X and status unchanged; IR still updates.
REQ-027 A change on switches after FETCH has no effect on the executing instruction.
REQ-028 A change on RUN takes effect only at the IDLE decision; an instruction in progress always completes.

Reset
REQ-029 RST_N low immediately forces state=IDLE; instruction, accumulator, index, status = 0; busy=0; synchronizer, debounce counter and debounced level = 0.
REQ-030 Reset during FETCH/EXEC/WRITE aborts the instruction; no partial register or flag update survives.
REQ-031 After release, the first instruction requires a fresh debounced STEP rising edge, or RUN=1.

Verification
REQ-032 Reset mid-EXEC (A=5 beforehand) -> all outputs 0 and state=00 before the next CLK edge.
REQ-033 switches=8'h15, STEP high 20 cycles, RUN=0 -> exactly one instruction: instruction=8'h15, accumulator=4'h5, status=4'b0000.
REQ-034 A=F then 8'h31 -> A=0, status=4'b1100; A=7 then 8'h31 -> A=8, status=4'b0011.
REQ-035 A=3 then 8'h45 -> A=E, status=4'b1010; X=0 then 8'hB0 -> X=F, C=1, N=1, V=0.
REQ-036 RUN=1, switches=8'hA0, X=0, 16 cycles from leaving IDLE -> X=4; busy low exactly one cycle in every four.
REQ-037 STEP glitch high 2 cycles (DEBOUNCE=3) -> no execution; a valid step while busy=1 -> ignored, no second instruction.
